id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_if.sv | 59 +++++
 rtl/id_ex_stage_alu_ctrl.sv | 42 ++++
 rtl/id_ex_stage.sv | 99 +++++++++
 tb/tb_id_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared constants for the ID/EX pipeline register:
//   - ALU operation codes driven on OP
//   - main-decoder ALU class codes (alu_op)
//   - R-type funct field values the stage understands
// No ports; imported by the interface, the ALU control decoder and the top.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        ALU_MEM    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_RSVD   = 2'b11
    } alu_class_t;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOP = 5'b01111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side request, the execute-side response and the
// handshake of the ID/EX register slot.
//   master : decode/execute environment (drives instruction, flush, out_ready)
//   slave  : the id_ex_stage register (drives in_ready, operands, controls)
// Parameter DATA_W : operand / immediate width.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DATA_W = 32
);
    // decode side
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic              flush;

    // execute side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [4:0]        OP;
    logic [4:0]        wr_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              illegal_op;

    modport master (
        output in_valid, rs_data, rt_data, imm, alu_op, funct,
               alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
               rt_addr, rd_addr, flush, out_ready,
        input  in_ready, out_valid, A, B, OP, wr_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_op
    );

    modport slave (
        input  in_valid, rs_data, rt_data, imm, alu_op, funct,
               alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
               rt_addr, rd_addr, flush, out_ready,
        output in_ready, out_valid, A, B, OP, wr_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal_op
    );

endinterface

// File: rtl/id_ex_stage_alu_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_stage_alu_ctrl
// Purely combinational ALU control decoder.
//   alu_op  in  2 : main-decoder class (mem / branch / R-type / reserved)
//   funct   in  6 : R-type function field
//   op      out 5 : ALU operation code
//   illegal out 1 : R-type with an unsupported funct
// ---------------------------------------------------------------------------
module id_ex_stage_alu_ctrl
    import id_ex_stage_pkg::*;
(
    input  alu_class_t alu_op,
    input  logic [5:0] funct,
    output logic [4:0] op,
    output logic       illegal
);

    always_comb begin
        op      = OP_NOP;
        illegal = 1'b0;
        case (alu_op)
            ALU_MEM:    op = OP_ADD;
            ALU_BRANCH: op = OP_SUB;
            ALU_RTYPE: begin
                case (funct)
                    FUNCT_ADD: op = OP_ADD;
                    FUNCT_SUB: op = OP_SUB;
                    FUNCT_SLT: op = OP_SLT;
                    FUNCT_AND: op = OP_AND;
                    FUNCT_OR:  op = OP_OR;
                    default: begin
                        op      = OP_NOP;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALU_RSVD:   op = OP_NOP;
            default:    op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Single-slot ID/EX pipeline register with valid/ready handshake.
//   clk    in : rising-edge clock
//   rst_n  in : asynchronous active-low reset
//   bus       : id_ex_stage_if.slave
//               decode side  -> in_valid/in_ready, operands, decode controls
//               flush        -> squash the held instruction
//               execute side -> out_valid/out_ready, A, B, OP, wr_addr,
//                               ex_* controls, illegal_op
// Parameter DATA_W : operand / immediate width.
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic              valid_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [4:0]        op_q;
    logic [4:0]        wr_addr_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;
    logic              illegal_q;

    logic [4:0]        op_dec;
    logic              illegal_dec;
    logic              ready;
    logic              load;

    id_ex_stage_alu_ctrl alu_ctrl (
        .alu_op  (alu_class_t'(bus.alu_op)),
        .funct   (bus.funct),
        .op      (op_dec),
        .illegal (illegal_dec)
    );

    // Slot is free when empty or when its contents leave this cycle.
    assign ready = !valid_q || bus.out_ready;
    assign load  = bus.in_valid && ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_NOP;
            wr_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (bus.flush || (!load && valid_q && bus.out_ready)) begin
            // Squash or plain drain: leave a bubble that can never commit.
            // Operand fields are left as they were; nothing consumes them.
            valid_q      <= 1'b0;
            op_q         <= OP_NOP;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (load) begin
            valid_q      <= 1'b1;
            a_q          <= bus.rs_data;
            b_q          <= bus.alu_src ? bus.imm : bus.rt_data;
            op_q         <= op_dec;
            wr_addr_q    <= bus.reg_dst ? bus.rd_addr : bus.rt_addr;
            // An unsupported R-type travels as a NOP that must not write state.
            reg_write_q  <= bus.reg_write && !illegal_dec;
            mem_read_q   <= bus.mem_read;
            mem_write_q  <= bus.mem_write && !illegal_dec;
            mem_to_reg_q <= bus.mem_to_reg;
            illegal_q    <= illegal_dec;
        end
    end

    assign bus.in_ready      = ready;
    assign bus.out_valid     = valid_q;
    assign bus.A             = a_q;
    assign bus.B             = b_q;
    assign bus.OP            = op_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_mem_to_reg = mem_to_reg_q;
    assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: a behavioural slot model compared
// against the DUT every falling edge, plus literal checks at key points.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the slot
    // ------------------------------------------------------------------
    bit [4:0] rtype_op [bit [5:0]];
    initial begin
        rtype_op[6'b100000] = 5'b00010;
        rtype_op[6'b100010] = 5'b00110;
        rtype_op[6'b101010] = 5'b00111;
        rtype_op[6'b100100] = 5'b00000;
        rtype_op[6'b100101] = 5'b00001;
    end

    function automatic void decode(input logic [1:0] cls, input logic [5:0] fn,
                                   output bit [4:0] op, output bit ill);
        bit [5:0] key;
        key = fn;
        ill = 1'b0;
        case (cls)
            2'b00:   op = 5'b00010;
            2'b01:   op = 5'b00110;
            2'b10: begin
                if (rtype_op.exists(key)) op = rtype_op[key];
                else begin
                    op  = 5'b01111;
                    ill = 1'b1;
                end
            end
            default: op = 5'b01111;
        endcase
    endfunction

    bit        m_valid = 1'b0;
    bit [31:0] m_a = '0, m_b = '0;
    bit [4:0]  m_op = 5'b01111, m_wr = '0;
    bit        m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_m2r = 1'b0, m_ill = 1'b0;
    bit        m_after_flush = 1'b1, m_after_reset = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_op = 5'b01111; m_wr = '0;
            m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0; m_ill = 1'b0;
            m_after_reset = 1'b1; m_after_flush = 1'b1;
        end else begin
            bit accept;
            bit [4:0] op;
            bit ill;
            accept = bus.in_valid && (!m_valid || bus.out_ready);
            m_after_reset = 1'b0;
            m_after_flush = 1'b0;
            if (bus.flush) begin
                m_valid = 1'b0; m_op = 5'b01111; m_ill = 1'b0;
                m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
                m_after_flush = 1'b1;
            end else if (accept) begin
                decode(bus.alu_op, bus.funct, op, ill);
                m_valid = 1'b1;
                m_a     = bus.rs_data;
                m_b     = bus.alu_src ? bus.imm : bus.rt_data;
                m_wr    = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
                m_op    = op;
                m_ill   = ill;
                m_rw    = bus.reg_write && !ill;
                m_mw    = bus.mem_write && !ill;
                m_mr    = bus.mem_read;
                m_m2r   = bus.mem_to_reg;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0;
            end
        end
    end

    // Compare process: outputs are stable on the falling edge.
    always @(negedge clk) begin
        chk("m.out_valid", bus.out_valid, m_valid);
        chk("m.in_ready", bus.in_ready, !m_valid || bus.out_ready);
        chk("m.ex_reg_write", bus.ex_reg_write, m_rw);
        chk("m.ex_mem_write", bus.ex_mem_write, m_mw);
        if (m_valid) begin
            chk("m.A", bus.A, m_a);
            chk("m.B", bus.B, m_b);
            chk("m.OP", bus.OP, m_op);
            chk("m.wr_addr", bus.wr_addr, m_wr);
            chk("m.ex_mem_read", bus.ex_mem_read, m_mr);
            chk("m.ex_mem_to_reg", bus.ex_mem_to_reg, m_m2r);
            chk("m.illegal_op", bus.illegal_op, m_ill);
        end
        if (m_after_flush) begin
            chk("m.bubble_OP", bus.OP, 5'b01111);
            chk("m.bubble_mem_read", bus.ex_mem_read, 1'b0);
            chk("m.bubble_mem_to_reg", bus.ex_mem_to_reg, 1'b0);
            chk("m.bubble_illegal", bus.illegal_op, 1'b0);
        end
        if (m_after_reset) begin
            chk("m.rst_A", bus.A, 32'h0);
            chk("m.rst_B", bus.B, 32'h0);
            chk("m.rst_wr_addr", bus.wr_addr, 32'h0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0;
        bus.alu_op = 2'b00; bus.funct = '0;
        bus.alu_src = 1'b0; bus.reg_dst = 1'b0; bus.reg_write = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_to_reg = 1'b0;
        bus.rt_addr = '0; bus.rd_addr = '0;
    endtask

    task automatic put(input logic [1:0] cls, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                       input bit src, input bit dst, input bit rw, input bit mr,
                       input bit mw, input bit m2r,
                       input logic [4:0] rta, input logic [4:0] rda);
        bus.in_valid = 1'b1;
        bus.alu_op = cls; bus.funct = fn;
        bus.rs_data = rs; bus.rt_data = rt; bus.imm = im;
        bus.alu_src = src; bus.reg_dst = dst; bus.reg_write = rw;
        bus.mem_read = mr; bus.mem_write = mw; bus.mem_to_reg = m2r;
        bus.rt_addr = rta; bus.rd_addr = rda;
    endtask

    logic [5:0] fn_list [7] = '{6'b100000, 6'b100010, 6'b101010, 6'b100100,
                                6'b100101, 6'b100111, 6'b000000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst.out_valid", bus.out_valid, 1'b0);
        chk("rst.A", bus.A, 32'h0);
        chk("rst.B", bus.B, 32'h0);
        chk("rst.OP", bus.OP, 5'b01111);
        chk("rst.wr_addr", bus.wr_addr, 5'd0);
        chk("rst.ex_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 4'b0000);
        chk("rst.illegal_op", bus.illegal_op, 1'b0);
        chk("rst.in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        // R-type add
        put(2'b10, 6'b100000, 32'd5, 32'd7, 32'h1234, 0, 1, 1, 0, 0, 0, 5'd3, 5'd9);
        tick();
        chk("add.out_valid", bus.out_valid, 1'b1);
        chk("add.A", bus.A, 32'd5);
        chk("add.B", bus.B, 32'd7);
        chk("add.OP", bus.OP, 5'b00010);
        chk("add.wr_addr", bus.wr_addr, 5'd9);
        chk("add.ex_reg_write", bus.ex_reg_write, 1'b1);

        // lw, back to back
        put(2'b00, 6'b100111, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 1, 0, 1, 1, 0, 1, 5'd8, 5'd17);
        tick();
        chk("lw.A", bus.A, 32'h100);
        chk("lw.B", bus.B, 32'hFFFF_FFFC);
        chk("lw.OP", bus.OP, 5'b00010);
        chk("lw.wr_addr", bus.wr_addr, 5'd8);
        chk("lw.ex_mem_read", bus.ex_mem_read, 1'b1);
        chk("lw.illegal_op", bus.illegal_op, 1'b0);

        // sw held through a 3-cycle stall while a beq waits
        put(2'b00, 6'b000000, 32'h200, 32'h55, 32'd4, 1, 0, 0, 0, 1, 0, 5'd4, 5'd5);
        tick();
        bus.out_ready = 1'b0;
        put(2'b01, 6'b000000, 32'd3, 32'd3, 32'd8, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.in_ready", bus.in_ready, 1'b0);
            chk("stall.out_valid", bus.out_valid, 1'b1);
            chk("stall.A", bus.A, 32'h200);
            chk("stall.B", bus.B, 32'd4);
            chk("stall.OP", bus.OP, 5'b00010);
            chk("stall.ex_mem_write", bus.ex_mem_write, 1'b1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release.in_ready", bus.in_ready, 1'b1);
        tick();
        chk("beq.out_valid", bus.out_valid, 1'b1);
        chk("beq.A", bus.A, 32'd3);
        chk("beq.B", bus.B, 32'd3);
        chk("beq.OP", bus.OP, 5'b00110);
        chk("beq.ex_mem_write", bus.ex_mem_write, 1'b0);

        // flush with a held instruction and a new one offered
        put(2'b10, 6'b100101, 32'hF0, 32'h0F, 32'h0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd12);
        bus.flush = 1'b1;
        tick();
        chk("flush.out_valid", bus.out_valid, 1'b0);
        chk("flush.OP", bus.OP, 5'b01111);
        chk("flush.ex_reg_write", bus.ex_reg_write, 1'b0);
        chk("flush.illegal_op", bus.illegal_op, 1'b0);
        bus.flush = 1'b0;
        tick();
        chk("or.OP", bus.OP, 5'b00001);
        chk("or.wr_addr", bus.wr_addr, 5'd12);
        chk("or.A", bus.A, 32'hF0);

        // unsupported funct, then slt, and, reserved class
        put(2'b10, 6'b100111, 32'd1, 32'd2, 32'd0, 0, 1, 1, 0, 1, 0, 5'd2, 5'd3);
        tick();
        chk("ill.OP", bus.OP, 5'b01111);
        chk("ill.illegal_op", bus.illegal_op, 1'b1);
        chk("ill.ex_reg_write", bus.ex_reg_write, 1'b0);
        chk("ill.ex_mem_write", bus.ex_mem_write, 1'b0);
        chk("ill.out_valid", bus.out_valid, 1'b1);
        put(2'b10, 6'b101010, 32'd9, 32'd10, 32'd0, 0, 1, 1, 0, 0, 0, 5'd2, 5'd4);
        tick();
        chk("slt.OP", bus.OP, 5'b00111);
        chk("slt.illegal_op", bus.illegal_op, 1'b0);
        chk("slt.ex_reg_write", bus.ex_reg_write, 1'b1);
        put(2'b10, 6'b100100, 32'd9, 32'd10, 32'd0, 0, 1, 1, 0, 0, 0, 5'd2, 5'd4);
        tick();
        chk("and.OP", bus.OP, 5'b00000);
        put(2'b11, 6'b100111, 32'd1, 32'd1, 32'd0, 0, 0, 1, 0, 0, 0, 5'd6, 5'd7);
        tick();
        chk("rsvd.OP", bus.OP, 5'b01111);
        chk("rsvd.illegal_op", bus.illegal_op, 1'b0);

        // drain with nothing behind it
        idle();
        tick();
        chk("drain.out_valid", bus.out_valid, 1'b0);
        chk("drain.ex_reg_write", bus.ex_reg_write, 1'b0);

        // flush beats hold while stalled
        put(2'b10, 6'b100010, 32'd20, 32'd6, 32'd0, 0, 1, 1, 0, 0, 0, 5'd1, 5'd2);
        tick();
        bus.out_ready = 1'b0;
        put(2'b00, 6'b000000, 32'd1, 32'd2, 32'd3, 1, 0, 1, 1, 0, 1, 5'd3, 5'd4);
        bus.flush = 1'b1;
        tick();
        chk("stall_flush.out_valid", bus.out_valid, 1'b0);
        chk("stall_flush.OP", bus.OP, 5'b01111);
        bus.flush = 1'b0;
        tick();
        bus.out_ready = 1'b1;

        // asynchronous reset in the middle of a stall
        put(2'b10, 6'b100000, 32'h11, 32'h22, 32'h0, 0, 1, 1, 0, 0, 0, 5'd5, 5'd6);
        tick();
        bus.out_ready = 1'b0;
        put(2'b00, 6'b000000, 32'h33, 32'h0, 32'h44, 1, 0, 0, 0, 1, 0, 5'd7, 5'd8);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", bus.out_valid, 1'b0);
        chk("arst.A", bus.A, 32'h0);
        chk("arst.B", bus.B, 32'h0);
        chk("arst.OP", bus.OP, 5'b01111);
        chk("arst.wr_addr", bus.wr_addr, 5'd0);
        chk("arst.ex_reg_write", bus.ex_reg_write, 1'b0);
        chk("arst.in_ready", bus.in_ready, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst.out_valid", bus.out_valid, 1'b1);
        chk("post_rst.A", bus.A, 32'h33);
        chk("post_rst.B", bus.B, 32'h44);
        chk("post_rst.ex_mem_write", bus.ex_mem_write, 1'b1);
        tick();
        bus.out_ready = 1'b1;

        // mixed traffic: model-checked every cycle
        for (int i = 0; i < 40; i++) begin
            put(2'(i % 4), fn_list[i % 7], 32'(i * 17), 32'(i * 3 + 1), 32'hFFFF_0000 | 32'(i),
                i[0], i[1], i[2], i[3], !i[2], i[0] ^ i[1], 5'(i), 5'(31 - i));
            bus.in_valid  = (i % 3) != 2;
            bus.out_ready = (i % 4) != 3;
            bus.flush     = (i % 9) == 4;
            tick();
        end

        idle();
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
